// File: rtl/nios2_oci_dct_capture.sv
// Trace-capture ring buffer for the Nios II OCI debug path.
// Captures {dct_count, dct_buffer} beats while in CAPTURE, presents the oldest
// entry on a valid/ready read port, counts lost beats and sequences the
// end-of-test handshake (test_ending drains, test_has_ended aborts).
module nios2_oci_dct_capture #(
  parameter int DATA_W       = 30,
  parameter int COUNT_W      = 4,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int STOP_ON_FULL = 0,
  parameter int OVF_W        = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               test_ending,
  input  logic               test_has_ended,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic [COUNT_W-1:0] rd_count,
  output logic [ADDR_W:0]    level,
  output logic [OVF_W-1:0]   overflow_cnt,
  output logic [1:0]         state,
  output logic               done
);

  localparam int ENT_W = COUNT_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic                push_req, pop, full, mem_we;

  // Overflow count sticks at all-ones instead of wrapping.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign full      = (level_q == (ADDR_W+1)'(DEPTH));
  assign rd_valid  = (level_q != '0) && ((state_q == S_CAPTURE) || (state_q == S_DRAIN));
  assign {rd_count, rd_data} = mem[rd_ptr_q];
  assign pop       = rd_valid && rd_ready;
  assign push_req  = (state_q == S_CAPTURE) && (dct_count != '0);
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = (state_q == S_DONE);

  // Next-state: pointer/level bookkeeping, overflow policy and handshake FSM.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;

    if (test_has_ended) begin
      // Abort wins over everything; any beat or pop this cycle is discarded.
      state_d  = S_DONE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_req && (pop || !full)) begin
        // A pop in the same cycle frees a slot, so a full buffer still accepts.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!pop) level_d = level_q + 1'b1;
      end else if (push_req) begin
        ovf_d = sat_inc(ovf_q);
        if (STOP_ON_FULL == 0) begin
          // Overwrite the oldest entry: head moves past it, level stays full.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (!push_req) level_d = level_q - 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d  = S_CAPTURE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = '0;
          end
        end
        S_CAPTURE: begin
          if (test_ending) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (level_d == '0) state_d = S_DONE;
        end
        S_DONE: begin
          if (arm) begin
            state_d  = S_CAPTURE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Beat storage; contents are not reset and only meaningful under rd_valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= {dct_count, dct_buffer};
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: one overwrite-on-full and one
// drop-on-full instance share stimulus; a queue model tracks both.
module tb_nios2_oci_dct_capture;

  typedef logic [33:0] beat_t;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;

  logic        rv   [2];
  logic [29:0] rdat [2];
  logic [3:0]  rcnt [2];
  logic [4:0]  lvl  [2];
  logic [15:0] ovf  [2];
  logic [1:0]  st   [2];
  logic        dn   [2];

  int total;
  int bad;

  beat_t mq0[$];
  beat_t mq1[$];
  int    mst0, mst1, movf0, movf1;

  nios2_oci_dct_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .ADDR_W(4),
                          .STOP_ON_FULL(0), .OVF_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_count(rcnt[0]),
    .level(lvl[0]), .overflow_cnt(ovf[0]), .state(st[0]), .done(dn[0]));

  nios2_oci_dct_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .ADDR_W(4),
                          .STOP_ON_FULL(1), .OVF_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_count(rcnt[1]),
    .level(lvl[1]), .overflow_cnt(ovf[1]), .state(st[1]), .done(dn[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: FIFO as a queue; state 0..3 = idle/capture/drain/done.
  task automatic model_one(input int sof, inout beat_t qq[$], inout int s, inout int ov);
    bit    rvx, popx, pushx;
    beat_t b;
    rvx   = (qq.size() != 0) && (s == 1 || s == 2);
    popx  = rvx && rd_ready;
    pushx = (s == 1) && (dct_count != 0);
    b     = {dct_count, dct_buffer};
    if (test_has_ended) begin
      qq.delete();
      s = 3;
      return;
    end
    if (popx) void'(qq.pop_front());
    if (pushx) begin
      if (qq.size() < 16) qq.push_back(b);
      else begin
        if (ov < 65535) ov++;
        if (sof == 0) begin
          void'(qq.pop_front());
          qq.push_back(b);
        end
      end
    end
    case (s)
      0: if (arm) s = 1;
      1: if (test_ending) s = 2;
      2: if (qq.size() == 0) s = 3;
      default: if (arm) begin s = 1; qq.delete(); ov = 0; end
    endcase
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    mst0 = 0; mst1 = 0; movf0 = 0; movf1 = 0;
  endtask

  function automatic int e_lvl(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction
  function automatic int e_st(int k);
    return (k == 0) ? mst0 : mst1;
  endfunction
  function automatic int e_ovf(int k);
    return (k == 0) ? movf0 : movf1;
  endfunction
  function automatic beat_t e_head(int k);
    if (k == 0) return (mq0.size() != 0) ? mq0[0] : '0;
    return (mq1.size() != 0) ? mq1[0] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_one(0, mq0, mst0, movf0);
    model_one(1, mq1, mst1, movf1);
    #1;
  endtask

  task automatic drive(input logic a, input logic [29:0] d, input logic [3:0] c,
                       input logic te, input logic th, input logic rr);
    arm = a; dct_buffer = d; dct_count = c; test_ending = te; test_has_ended = th; rd_ready = rr;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rv[k], lvl[k], ovf[k], st[k], dn[k]} !== 25'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d got rv=%b lvl=%0d ovf=%0d st=%0d dn=%b want all zero",
                 k, rv[k], lvl[k], ovf[k], st[k], dn[k]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 30'(i), 4'd1, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lvl[k] !== 5'd5 || rv[k] !== 1'b1 || rdat[k] !== 30'd1 || st[k] !== 2'd1) begin
        bad++;
        $display("FAIL basic_fill dut%0d got lvl=%0d rv=%b data=%h st=%0d want 5 1 1 1",
                 k, lvl[k], rv[k], rdat[k], st[k]);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rv[k] !== 1'b1 || rdat[k] !== 30'(i) || rcnt[k] !== 4'd1) begin
          bad++;
          $display("FAIL basic_pop dut%0d got rv=%b data=%h cnt=%0d want 1 %h 1", k, rv[k], rdat[k], rcnt[k], i);
        end
      end
      drive(0, 0, 0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lvl[k] !== 5'd0 || rv[k] !== 1'b0) begin
        bad++;
        $display("FAIL basic_empty dut%0d got lvl=%0d rv=%b want 0 0", k, lvl[k], rv[k]);
      end
    end
  endtask

  task automatic restart();
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full();
    restart();
    for (int i = 0; i < 20; i++) begin
      drive(0, 30'(i), 4'd1, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lvl[k] !== 5'd16 || ovf[k] !== 16'd4) begin
        bad++;
        $display("FAIL full_level dut%0d got lvl=%0d ovf=%0d want 16 4", k, lvl[k], ovf[k]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rdat[0] !== 30'(i + 4)) begin
        bad++;
        $display("FAIL full_overwrite_order got=%h want=%h", rdat[0], i + 4);
      end
      total++;
      if (rdat[1] !== 30'(i)) begin
        bad++;
        $display("FAIL full_drop_order got=%h want=%h", rdat[1], i);
      end
      drive(0, 0, 0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(0, 30'(100 + i), 4'd2, 0, 0, 0); tick();
    end
    drive(0, 30'd200, 4'd2, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lvl[k] !== 5'd16 || ovf[k] !== 16'd4 || rdat[k] !== 30'd101) begin
        bad++;
        $display("FAIL full_push_pop dut%0d got lvl=%0d ovf=%0d head=%h want 16 4 101",
                 k, lvl[k], ovf[k], rdat[k]);
      end
    end
  endtask

  task automatic test_drain();
    restart();
    for (int i = 0; i < 6; i++) begin
      drive(0, 30'(300 + i), 4'd1, 0, 0, 0); tick();
    end
    drive(0, 30'd306, 4'd1, 1, 0, 0); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (st[k] !== 2'd2 || lvl[k] !== 5'd7) begin
        bad++;
        $display("FAIL drain_entry dut%0d got st=%0d lvl=%0d want 2 7", k, st[k], lvl[k]);
      end
    end
    drive(0, 30'h3ff, 4'd3, 0, 0, 0); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lvl[k] !== 5'd7) begin
        bad++;
        $display("FAIL drain_no_write dut%0d got lvl=%0d want 7", k, lvl[k]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rdat[k] !== 30'(300 + i)) begin
          bad++;
          $display("FAIL drain_order dut%0d got=%h want=%h", k, rdat[k], 300 + i);
        end
      end
      drive(0, 30'h3ff, 4'd3, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (st[k] !== 2'd3 || dn[k] !== 1'b1 || rv[k] !== 1'b0) begin
        bad++;
        $display("FAIL drain_done dut%0d got st=%0d done=%b rv=%b want 3 1 0", k, st[k], dn[k], rv[k]);
      end
    end
  endtask

  task automatic test_abort();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 30'(500 + i), 4'd5, 0, 0, 0); tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 1); tick();
    end
    drive(0, 30'd777, 4'd1, 1, 1, 1); tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (st[k] !== 2'd3 || lvl[k] !== 5'd0 || rv[k] !== 1'b0 || dn[k] !== 1'b1 || ovf[k] !== 16'd4) begin
        bad++;
        $display("FAIL abort dut%0d got st=%0d lvl=%0d rv=%b dn=%b ovf=%0d want 3 0 0 1 4",
                 k, st[k], lvl[k], rv[k], dn[k], ovf[k]);
      end
    end
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (st[k] !== 2'd1 || ovf[k] !== 16'd0 || lvl[k] !== 5'd0) begin
        bad++;
        $display("FAIL rearm dut%0d got st=%0d ovf=%0d lvl=%0d want 1 0 0", k, st[k], ovf[k], lvl[k]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 30'(i), 4'd1, 0, 0, 0); tick();
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rv[k], lvl[k], ovf[k], st[k], dn[k]} !== 25'd0) begin
        bad++;
        $display("FAIL async_reset dut%0d got rv=%b lvl=%0d ovf=%0d st=%0d dn=%b want all zero",
                 k, rv[k], lvl[k], ovf[k], st[k], dn[k]);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 15) == 0), 30'($urandom),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 2) != 0));
      tick();
      for (int k = 0; k < 2; k++) begin
        logic er;
        er = (e_lvl(k) != 0) && (e_st(k) == 1 || e_st(k) == 2);
        total++;
        if ({rv[k], lvl[k], ovf[k], st[k], dn[k]} !==
            {er, 5'(e_lvl(k)), 16'(e_ovf(k)), 2'(e_st(k)), (e_st(k) == 3)}) begin
          bad++;
          $display("FAIL random_ctrl dut%0d cyc=%0d got rv=%b lvl=%0d ovf=%0d st=%0d dn=%b want rv=%b lvl=%0d ovf=%0d st=%0d",
                   k, n, rv[k], lvl[k], ovf[k], st[k], dn[k], er, e_lvl(k), e_ovf(k), e_st(k));
        end
        if (er) begin
          total++;
          if ({rcnt[k], rdat[k]} !== e_head(k)) begin
            bad++;
            $display("FAIL random_head dut%0d cyc=%0d got=%h want=%h", k, n, {rcnt[k], rdat[k]}, e_head(k));
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_drain();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
